// File: rtl/game_select_ctrl.sv
// Game scheduler: debounced buttons, round-robin game switching and the shared segment display.
// Define GAME_SPLASH_EN to show the new game's number for SPLASH_CYCLES after each switch.
module game_select_ctrl #(
  parameter int NUM_GAMES       = 4,
  parameter int DEBOUNCE_CYCLES = 5000,
  parameter int SPLASH_CYCLES   = 20000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [3:0]             btn_raw,
  input  logic                   btn_switch,
  input  logic [8*NUM_GAMES-1:0] game_seg,
  output logic [NUM_GAMES-1:0]   game_en,
  output logic [NUM_GAMES-1:0]   game_clr,
  output logic [4*NUM_GAMES-1:0] game_btn,
  output logic [3:0]             game_idx,
  output logic [7:0]             seg_out
);

  localparam int              DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]      LAST_IDX = 4'(NUM_GAMES - 1);

`ifdef GAME_SPLASH_EN
  typedef enum logic [1:0] {RUN, CLEAR, SPLASH} state_t;
`else
  typedef enum logic [1:0] {RUN, CLEAR} state_t;
`endif

  function automatic logic [3:0] advance(input logic [3:0] idx);
    return (idx == LAST_IDX) ? 4'd0 : idx + 4'd1;
  endfunction

`ifdef GAME_SPLASH_EN
  // Segment pattern of the human-facing game number idx+1.
  function automatic logic [7:0] digit(input logic [3:0] idx);
    case (idx)
      4'd0:    return 8'h06;
      4'd1:    return 8'h5B;
      4'd2:    return 8'h4F;
      4'd3:    return 8'h66;
      4'd4:    return 8'h6D;
      4'd5:    return 8'h7D;
      4'd6:    return 8'h07;
      4'd7:    return 8'h7F;
      4'd8:    return 8'h6F;
      default: return 8'h00;
    endcase
  endfunction
`endif

  logic [4:0]      raw_p0, sync_p1, sync_p2, level_p3, press_p3;
  logic [DB_W-1:0] db_cnt [5];

  assign raw_p0 = {btn_switch, btn_raw};

  // Stage p1/p2: synchronizer; stage p3: debounce counter, accepted level and press pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p1  <= '0;
      sync_p2  <= '0;
      level_p3 <= '0;
      press_p3 <= '0;
      for (int i = 0; i < 5; i++) db_cnt[i] <= '0;
    end else begin
      sync_p1 <= raw_p0;
      sync_p2 <= sync_p1;
      for (int i = 0; i < 5; i++) begin
        press_p3[i] <= 1'b0;
        if (sync_p2[i] == level_p3[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_cnt[i]   <= '0;
          level_p3[i] <= sync_p2[i];
          press_p3[i] <= sync_p2[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  state_t     state, state_next;
  logic [3:0] idx_next;
  logic [7:0] seg_sel, seg_next;
  logic       sw_press;
  logic [3:0] game_press;

  assign sw_press   = press_p3[4];
  assign game_press = press_p3[3:0];
  assign seg_sel    = 8'(game_seg >> {game_idx, 3'b000});
  assign game_en    = NUM_GAMES'(1) << game_idx;

`ifdef GAME_SPLASH_EN
  localparam int              SP_W    = $clog2(SPLASH_CYCLES + 1);
  localparam logic [SP_W-1:0] SP_LAST = SP_W'(SPLASH_CYCLES - 1);
  logic [SP_W-1:0] splash_cnt;

  always_ff @(posedge clk) begin
    if (rst || state != SPLASH) splash_cnt <= '0;
    else if (splash_cnt != SP_LAST) splash_cnt <= splash_cnt + SP_W'(1);
  end
`endif

  always_comb begin
    state_next = state;
    idx_next   = game_idx;
    game_btn   = '0;
    game_clr   = '0;
    case (state)
      RUN: begin
        // A switch press wins over any game press on the same cycle.
        if (sw_press) begin
          state_next = CLEAR;
          idx_next   = advance(game_idx);
        end else begin
          game_btn = (4*NUM_GAMES)'(game_press) << {game_idx, 2'b00};
        end
      end
      CLEAR: begin
        game_clr = NUM_GAMES'(1) << game_idx;
`ifdef GAME_SPLASH_EN
        state_next = SPLASH;
`else
        state_next = RUN;
`endif
      end
`ifdef GAME_SPLASH_EN
      SPLASH: begin
        if (sw_press) begin
          state_next = CLEAR;
          idx_next   = advance(game_idx);
        end else if (splash_cnt == SP_LAST) begin
          state_next = RUN;
        end
      end
`endif
      default: state_next = RUN;
    endcase

    // Hold the display through CLEAR so it never flashes the wrong game.
    seg_next = seg_sel;
    if (state_next == CLEAR) seg_next = seg_out;
`ifdef GAME_SPLASH_EN
    else if (state_next == SPLASH) seg_next = digit(idx_next);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      game_idx <= '0;
      seg_out  <= '0;
    end else begin
      state    <= state_next;
      game_idx <= idx_next;
      seg_out  <= seg_next;
    end
  end

endmodule

// File: tb/tb_game_select_ctrl.sv
// Self-checking bench for game_select_ctrl: directed scenarios plus random button traffic
// compared against a window-based debounce / phase-based scheduler reference model.
`timescale 1ns/1ps
module tb_game_select_ctrl;
  localparam int N = 4, D = 16, S = 32;
  localparam int P_RUN = 0, P_CLEAR = 1, P_SPLASH = 2;
`ifdef GAME_SPLASH_EN
  localparam bit SPLASH_EN = 1'b1;
`else
  localparam bit SPLASH_EN = 1'b0;
`endif
  localparam logic [7:0] DIGITS [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                         8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

  logic           clk = 1'b0, rst = 1'b1, btn_switch = 1'b0;
  logic [3:0]     btn_raw = 4'd0;
  logic [8*N-1:0] game_seg = 32'hD4C3B2A1;
  logic [N-1:0]   game_en, game_clr;
  logic [4*N-1:0] game_btn;
  logic [3:0]     game_idx;
  logic [7:0]     seg_out;
  int errors = 0, checks = 0;

  game_select_ctrl #(.NUM_GAMES(N), .DEBOUNCE_CYCLES(D), .SPLASH_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .btn_switch(btn_switch), .game_seg(game_seg),
    .game_en(game_en), .game_clr(game_clr), .game_btn(game_btn), .game_idx(game_idx),
    .seg_out(seg_out));

  always #5 clk = ~clk;

  // Reference model: a button level is accepted once the last D synchronized samples all
  // disagree with it; the scheduler is tracked as a phase plus splash cycles remaining.
  logic [4:0] m_raw_h[$];
  logic [4:0] m_samp[$];
  logic [4:0] m_level = '0, m_press = '0;
  int         m_idx = 0, m_phase = P_RUN, m_left = 0;
  logic [7:0] m_seg = '0;

  function automatic logic [7:0] seg_of(input int g);
    return game_seg[8*g +: 8];
  endfunction

  task automatic model_step();
    logic [4:0] raw, s, np;
    int old_idx;
    bit sw, all_diff;
    raw = {btn_switch, btn_raw};
    if (rst) begin
      m_raw_h = '{5'd0, 5'd0};
      m_samp.delete();
      m_level = '0; m_press = '0; m_idx = 0; m_phase = P_RUN; m_left = 0; m_seg = '0;
      return;
    end
    old_idx = m_idx;
    sw = m_press[4];
    case (m_phase)
      P_RUN:   if (sw) begin m_idx = (m_idx + 1) % N; m_phase = P_CLEAR; end
      P_CLEAR: begin m_phase = SPLASH_EN ? P_SPLASH : P_RUN; m_left = S; end
      default: begin
        if (sw) begin m_idx = (m_idx + 1) % N; m_phase = P_CLEAR; end
        else begin m_left--; if (m_left == 0) m_phase = P_RUN; end
      end
    endcase
    if (m_phase == P_SPLASH) m_seg = DIGITS[m_idx + 1];
    else if (m_phase != P_CLEAR) m_seg = seg_of(old_idx);
    s = m_raw_h[0];
    m_raw_h.push_back(raw);
    void'(m_raw_h.pop_front());
    m_samp.push_back(s);
    if (m_samp.size() > D) void'(m_samp.pop_front());
    np = '0;
    if (m_samp.size() == D) begin
      for (int b = 0; b < 5; b++) begin
        all_diff = 1'b1;
        foreach (m_samp[j]) if (m_samp[j][b] == m_level[b]) all_diff = 1'b0;
        if (all_diff) begin m_level[b] = ~m_level[b]; np[b] = m_level[b]; end
      end
    end
    m_press = np;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic press_switch();
    btn_switch = 1'b1;
    repeat (40) tick();
    btn_switch = 1'b0;
    repeat (30) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++; if (game_idx !== 4'd0) begin errors++; $display("FAIL reset_idx got=%0d want=0", game_idx); end
    checks++; if (game_en !== 4'b0001) begin errors++; $display("FAIL reset_en got=%b want=0001", game_en); end
    checks++; if (game_clr !== 4'b0000) begin errors++; $display("FAIL reset_clr got=%b want=0000", game_clr); end
    checks++; if (game_btn !== 16'h0000) begin errors++; $display("FAIL reset_btn got=%h want=0000", game_btn); end
    checks++; if (seg_out !== 8'h00) begin errors++; $display("FAIL reset_seg got=%h want=00", seg_out); end
    rst = 1'b0;
    repeat (100) tick();
    checks++; if (game_idx !== 4'd0) begin errors++; $display("FAIL idle_idx got=%0d want=0", game_idx); end
    checks++; if (game_en !== 4'b0001) begin errors++; $display("FAIL idle_en got=%b want=0001", game_en); end
    checks++; if (game_clr !== 4'b0000) begin errors++; $display("FAIL idle_clr got=%b want=0000", game_clr); end
    checks++; if (seg_out !== 8'hA1) begin errors++; $display("FAIL idle_seg got=%h want=a1", seg_out); end
  endtask

  task automatic test_debounce();
    int first_at, cnt, other, glitch;
    first_at = -1; cnt = 0; other = 0; glitch = 0;
    btn_raw[0] = 1'b1;
    for (int c = 1; c <= 70; c++) begin
      tick();
      if (game_btn[0]) begin cnt++; if (first_at < 0) first_at = c; end
      if (game_btn[15:1] !== 15'd0) other++;
      if (c == 40) btn_raw[0] = 1'b0;
    end
    checks++; if (cnt != 1) begin errors++; $display("FAIL press_count got=%0d want=1", cnt); end
    checks++; if (first_at != 18) begin errors++; $display("FAIL press_latency got=%0d want=18", first_at); end
    checks++; if (other != 0) begin errors++; $display("FAIL press_other_bits got=%0d want=0", other); end
    btn_raw[0] = 1'b1;
    for (int c = 1; c <= 50; c++) begin
      tick();
      if (game_btn !== 16'h0000) glitch++;
      if (c == 10) btn_raw[0] = 1'b0;
    end
    checks++; if (glitch != 0) begin errors++; $display("FAIL glitch_pulses got=%0d want=0", glitch); end
  endtask

  task automatic test_switch();
    int clr_cnt, clr_at, sp_bad, d, exp_idx;
    logic [N-1:0] clr_val;
    for (int p = 0; p < 4; p++) begin
      exp_idx = (p + 1) % N; clr_cnt = 0; clr_at = -1; sp_bad = 0; clr_val = '0;
      btn_switch = 1'b1;
      for (int c = 1; c <= 80; c++) begin
        tick();
        if (game_clr !== '0) begin clr_cnt++; clr_val = game_clr; clr_at = c; end
        if (p == 0 && clr_at > 0) begin
          d = c - clr_at;
`ifdef GAME_SPLASH_EN
          if (d >= 1 && d <= S && seg_out !== 8'h5B) sp_bad++;
          if (d == S + 1 && seg_out !== seg_of(1)) sp_bad++;
`else
          if (d == 1 && seg_out !== seg_of(1)) sp_bad++;
`endif
        end
        if (c == 40) btn_switch = 1'b0;
      end
      checks++; if (clr_cnt != 1) begin errors++; $display("FAIL switch%0d_clr_count got=%0d want=1", p, clr_cnt); end
      checks++; if (clr_val !== N'(1 << exp_idx)) begin errors++; $display("FAIL switch%0d_clr got=%b want=%b", p, clr_val, N'(1 << exp_idx)); end
      checks++; if (game_idx !== 4'(exp_idx)) begin errors++; $display("FAIL switch%0d_idx got=%0d want=%0d", p, game_idx, exp_idx); end
      if (p == 0) begin
        checks++; if (sp_bad != 0) begin errors++; $display("FAIL switch_display bad_cycles=%0d want=0", sp_bad); end
      end
    end
  endtask

  task automatic test_splash_drop();
    int found, cnt, cnt2;
    logic [4*N-1:0] val;
    found = 0; cnt = 0; cnt2 = 0; val = '0;
    press_switch();
    btn_switch = 1'b1;
    for (int c = 0; c < 40 && found == 0; c++) begin tick(); if (game_clr !== '0) found = 1; end
    checks++; if (found == 0) begin errors++; $display("FAIL drop_clr_timeout got=none want=clear pulse"); end
    btn_raw[1] = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      tick();
      if (game_btn !== '0) cnt++;
      if (c == 20) btn_switch = 1'b0;
      if (c == 40) btn_raw[1] = 1'b0;
    end
    checks++; if (cnt != (SPLASH_EN ? 0 : 1)) begin errors++; $display("FAIL drop_splash_pulses got=%0d want=%0d", cnt, SPLASH_EN ? 0 : 1); end
    checks++; if (game_idx !== 4'd2) begin errors++; $display("FAIL drop_idx got=%0d want=2", game_idx); end
    repeat (20) tick();
    btn_raw[1] = 1'b1;
    for (int c = 1; c <= 50; c++) begin
      tick();
      if (game_btn !== '0) begin cnt2++; val = game_btn; end
      if (c == 30) btn_raw[1] = 1'b0;
    end
    checks++; if (cnt2 != 1) begin errors++; $display("FAIL run_press_count got=%0d want=1", cnt2); end
    checks++; if (val !== 16'h0200) begin errors++; $display("FAIL run_press_bits got=%h want=0200", val); end
  endtask

  task automatic test_switch_wins();
    int gb, clr_cnt, clr_at, sp_bad, d;
    logic [N-1:0] clr1, clr2;
    gb = 0; clr_cnt = 0; clr_at = -1; sp_bad = 0; clr1 = '0; clr2 = '0;
    btn_switch = 1'b1; btn_raw[2] = 1'b1;
    for (int c = 1; c <= 102; c++) begin
      tick();
      if (game_btn !== '0) gb++;
      if (game_clr !== '0) begin
        clr_cnt++;
        if (clr_cnt == 1) clr1 = game_clr; else begin clr2 = game_clr; clr_at = c; end
      end
      if (clr_at > 0) begin
        d = c - clr_at;
`ifdef GAME_SPLASH_EN
        if (d >= 1 && d <= S && seg_out !== 8'h06) sp_bad++;
        if (d == S + 1 && seg_out !== seg_of(0)) sp_bad++;
`else
        if (d == 1 && seg_out !== seg_of(0)) sp_bad++;
`endif
      end
      if (c == 16) begin btn_switch = 1'b0; btn_raw[2] = 1'b0; end
      if (c == 32) btn_switch = 1'b1;
      if (c == 72) btn_switch = 1'b0;
    end
    checks++; if (gb != 0) begin errors++; $display("FAIL coincide_game_pulses got=%0d want=0", gb); end
    checks++; if (clr_cnt != 2) begin errors++; $display("FAIL coincide_clr_count got=%0d want=2", clr_cnt); end
    checks++; if (clr1 !== 4'b1000) begin errors++; $display("FAIL coincide_clr1 got=%b want=1000", clr1); end
    checks++; if (clr2 !== 4'b0001) begin errors++; $display("FAIL resplash_clr2 got=%b want=0001", clr2); end
    checks++; if (game_idx !== 4'd0) begin errors++; $display("FAIL resplash_idx got=%0d want=0", game_idx); end
    checks++; if (sp_bad != 0) begin errors++; $display("FAIL resplash_display bad_cycles=%0d want=0", sp_bad); end
  endtask

  task automatic test_reset_mid_splash();
    int found;
    found = 0;
    press_switch();
    press_switch();
    btn_switch = 1'b1;
    for (int c = 0; c < 40 && found == 0; c++) begin tick(); if (game_clr !== '0) found = 1; end
    checks++; if (found == 0) begin errors++; $display("FAIL midrst_clr_timeout got=none want=clear pulse"); end
    repeat (5) tick();
    rst = 1'b1; btn_switch = 1'b0;
    tick();
    checks++; if (game_idx !== 4'd0) begin errors++; $display("FAIL midrst_idx got=%0d want=0", game_idx); end
    checks++; if (game_en !== 4'b0001) begin errors++; $display("FAIL midrst_en got=%b want=0001", game_en); end
    checks++; if (game_clr !== 4'b0000) begin errors++; $display("FAIL midrst_clr got=%b want=0000", game_clr); end
    checks++; if (game_btn !== 16'h0000) begin errors++; $display("FAIL midrst_btn got=%h want=0000", game_btn); end
    checks++; if (seg_out !== 8'h00) begin errors++; $display("FAIL midrst_seg got=%h want=00", seg_out); end
    rst = 1'b0;
    repeat (30) tick();
    checks++; if (game_idx !== 4'd0) begin errors++; $display("FAIL postrst_idx got=%0d want=0", game_idx); end
  endtask

  task automatic test_random();
    int hold [5];
    logic [N-1:0]   e_en, e_clr;
    logic [4*N-1:0] e_btn;
    for (int b = 0; b < 5; b++) hold[b] = $urandom_range(1, 40);
    for (int c = 0; c < 3000 && errors < 20; c++) begin
      for (int b = 0; b < 5; b++) begin
        hold[b]--;
        if (hold[b] == 0) begin
          if (b == 4) btn_switch = ~btn_switch; else btn_raw[b] = ~btn_raw[b];
          hold[b] = $urandom_range(4, 60);
        end
      end
      rst = ($urandom_range(0, 1499) == 0);
      if ($urandom_range(0, 199) == 0) game_seg = $urandom;
      tick();
      e_en = '0; e_en[m_idx] = 1'b1;
      e_clr = (m_phase == P_CLEAR) ? e_en : '0;
      e_btn = '0;
      if (m_phase == P_RUN && !m_press[4]) for (int k = 0; k < 4; k++) e_btn[4*m_idx + k] = m_press[k];
      checks++; if (game_idx !== 4'(m_idx)) begin errors++; $display("FAIL rnd_idx cyc=%0d got=%0d want=%0d", c, game_idx, m_idx); end
      checks++; if (game_en !== e_en) begin errors++; $display("FAIL rnd_en cyc=%0d got=%b want=%b", c, game_en, e_en); end
      checks++; if (game_clr !== e_clr) begin errors++; $display("FAIL rnd_clr cyc=%0d got=%b want=%b", c, game_clr, e_clr); end
      checks++; if (game_btn !== e_btn) begin errors++; $display("FAIL rnd_btn cyc=%0d got=%h want=%h", c, game_btn, e_btn); end
      checks++; if (seg_out !== m_seg) begin errors++; $display("FAIL rnd_seg cyc=%0d got=%h want=%h", c, seg_out, m_seg); end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_switch();
    test_splash_drop();
    test_switch_wins();
    test_reset_mid_splash();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
